clock_receiver: RTL
===================

Name: clock_receiver

Overview:
- Receive end of the serial counter link: deserializes 8N1 UART frames on RxD and reassembles 5-byte packets (header byte, then 32-bit counter LSB byte first).
- Presents the counter with a one-cycle valid strobe.
- Sits on the host-side or second-board FPGA, running on the 50 MHz fast clock. Recovers the counter value sent periodically by the clock transmitter.

Parameters:
- CLK_FREQ, 50000000, clk frequency in Hz.
- BAUD, 115200, serial bit rate; BIT_CYCLES = CLK_FREQ/BAUD, truncated integer division.
- EXPECT_HEADER, 8'h00, header to accept; 8'h00 means accept any non-zero header.
- TIMEOUT_CYCLES, 10*BIT_CYCLES*4, max idle clk cycles between end of one byte and start bit of the next within a packet.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- RxD  input  1  asynchronous serial input; idle high.
- counter_out  output  32  last successfully received counter.
- header_out  output  8  header of last successful packet.
- frame_valid  output  1  one-cycle pulse when counter_out/header_out update.
- frame_err  output  1  one-cycle pulse on aborted packet.
- busy  output  1  high while a packet is partially received (header accepted, fewer than 4 counter bytes received).

Behaviour:
- Reset (sync, active-high): counter_out=0, header_out=0, frame_valid=0, frame_err=0, busy=0. RxD synchronizer flops reset to 1. Both FSMs go to idle; the byte counter and timeout counter clear. Reset mid-packet discards partial data with no frame_err.
- RxD passes through a 2-flop synchronizer; all sampling uses the synchronized value.
- Byte engine FSM, states: b_idle, b_start, b_data, b_stop.
  - b_idle: a 1->0 transition on synchronized RxD enters b_start and loads the bit timer.
  - b_start: sample at BIT_CYCLES/2. If the sample is high, treat it as a glitch and return to b_idle with no output. If low, enter b_data.
  - b_data: 8 samples, each BIT_CYCLES apart, shifted in LSB first.
  - b_stop: sample one BIT_CYCLES later. If high, byte_valid pulses 1 cycle. If low, byte_err pulses 1 cycle. Either way, return to b_idle in the same cycle, so back-to-back start bits are accepted.
- Packet FSM, states: p_idle, p_collect, p_done, p_abort.
  - p_idle: on byte_valid with byte != 0, and (EXPECT_HEADER==0 or byte==EXPECT_HEADER), latch header, clear byte_count, enter p_collect. A non-matching or zero header byte is dropped silently, with no frame_err. byte_err in p_idle is ignored.
  - p_collect: on byte_valid, place the byte at counter bits [8*byte_count+7 : 8*byte_count] and increment byte_count. After the 4th byte, go to p_done. On byte_err, go to p_abort. If the timeout counter (cleared on each byte_valid, counting while the byte engine is in b_idle) reaches TIMEOUT_CYCLES, go to p_abort.
  - p_done: update counter_out/header_out, pulse frame_valid for 1 cycle, go to p_idle.
  - p_abort: pulse frame_err for 1 cycle, leave counter_out/header_out unchanged, go to p_idle.
- Latency: frame_valid is asserted 2 clk cycles after the stop-bit sample of the last byte.
- busy = (packet state == p_collect).
- frame_valid and frame_err are never high in the same cycle.
- A byte_valid in the same cycle as a timeout expiry counts as received; the timeout loses.

Decomposition:
- Package clock_link_pkg holds:
  - byte-engine and packet-FSM state encodings;
  - FRAME_BYTES=5, DATA_BITS=8;
  - the function computing BIT_CYCLES from CLK_FREQ/BAUD.
- Sub-module serial_byte_receiver:
  - contains the synchronizer, bit timer and byte engine;
  - outputs byte_data[7:0], byte_valid, byte_err and rx_idle.
- clock_receiver instantiates it and holds the packet FSM and timeout counter.

Test Plan (bench uses CLK_FREQ=1000000, BAUD=100000, so BIT_CYCLES=10; TIMEOUT_CYCLES=400):
- Nominal: bytes A5 78 56 34 12 back-to-back -> counter_out=32'h12345678, header_out=8'hA5, frame_valid high exactly 1 cycle, busy low afterwards.
- Header filter (EXPECT_HEADER=8'hA5): send 3C 11 22 33 44, then A5 DD CC BB AA -> no frame_err; single frame_valid with counter_out=32'hAABBCCDD.
- Framing error: A5 01 02, then a byte with stop bit 0 -> frame_err 1-cycle pulse, counter_out unchanged. A following good frame A5 04 03 02 01 -> 32'h01020304.
- Timeout: A5 01 02, then RxD held high for 500 cycles -> frame_err pulse at 400 idle cycles, busy drops. Next good frame is accepted.
- Glitch: RxD low for 3 cycles in idle -> no byte_valid, no outputs change. Next frame is received correctly.
- Reset mid-packet: rst high for 1 cycle after byte 2 -> all outputs 0, no frame_err. A subsequent full frame A5 78 56 34 12 -> 32'h12345678.

Source files
------------

// File: rtl/clock_link_pkg.sv
// Shared definitions for the serial counter link: FSM encodings, framing
// constants and the bit-period helper.
package clock_link_pkg;

  typedef enum logic [1:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP
  } byte_state_e;

  typedef enum logic [1:0] {
    P_IDLE,
    P_COLLECT,
    P_DONE,
    P_ABORT
  } pkt_state_e;

  localparam int unsigned FRAME_BYTES = 5;
  localparam int unsigned DATA_BITS   = 8;

  function automatic int unsigned bit_cycles(input int unsigned clk_freq,
                                             input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/serial_byte_receiver.sv
// 8N1 byte deserializer: RxD synchronizer, bit timer and byte engine.
// Emits one-cycle byte_valid/byte_err strobes at the stop-bit sample.
module serial_byte_receiver
  import clock_link_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 434
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] byte_data_o,
  output logic       byte_valid_o,
  output logic       byte_err_o,
  output logic       rx_idle_o
);

  localparam int unsigned TW = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [TW-1:0] HALF_LOAD = TW'(BIT_CYCLES / 2 - 1);
  localparam logic [TW-1:0] FULL_LOAD = TW'(BIT_CYCLES - 1);

  byte_state_e   state_q, state_d;
  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tick;

  assign tick = (timer_q == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= B_IDLE;
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    case (state_q)
      B_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          state_d = B_START;
          timer_d = HALF_LOAD;
        end
      end
      B_START: begin
        if (!tick) begin
          timer_d = timer_q - 1'b1;
        end else if (rx_sync_q) begin
          state_d = B_IDLE;
        end else begin
          state_d   = B_DATA;
          timer_d   = FULL_LOAD;
          bit_idx_d = '0;
        end
      end
      B_DATA: begin
        if (!tick) begin
          timer_d = timer_q - 1'b1;
        end else begin
          shift_d = {rx_sync_q, shift_q[7:1]};
          timer_d = FULL_LOAD;
          if (bit_idx_q == 3'(DATA_BITS - 1)) state_d = B_STOP;
          else bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      B_STOP: begin
        // Return to idle at the mid-stop sample so a back-to-back start edge is seen.
        if (!tick) timer_d = timer_q - 1'b1;
        else state_d = B_IDLE;
      end
      default: state_d = B_IDLE;
    endcase
  end

  always_comb begin
    byte_data_o  = shift_q;
    byte_valid_o = (state_q == B_STOP) && tick && rx_sync_q;
    byte_err_o   = (state_q == B_STOP) && tick && !rx_sync_q;
    rx_idle_o    = (state_q == B_IDLE);
  end

endmodule

// File: rtl/clock_receiver.sv
// Receive end of the serial counter link: assembles header + 32-bit counter
// (LSB first) from received bytes, with header filtering and inter-byte timeout.
module clock_receiver
  import clock_link_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 50000000,
  parameter int unsigned BAUD           = 115200,
  parameter logic [7:0]  EXPECT_HEADER  = 8'h00,
  parameter int unsigned TIMEOUT_CYCLES = 10 * bit_cycles(CLK_FREQ, BAUD) * 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RxD,
  output logic [31:0] counter_out,
  output logic [7:0]  header_out,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int unsigned BIT_CYCLES = bit_cycles(CLK_FREQ, BAUD);
  localparam logic [1:0]  LAST_IDX   = 2'(FRAME_BYTES - 2);

  logic [7:0] byte_data;
  logic       byte_valid, byte_err, rx_idle;

  serial_byte_receiver #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_byte_rx (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_i        (RxD),
    .byte_data_o (byte_data),
    .byte_valid_o(byte_valid),
    .byte_err_o  (byte_err),
    .rx_idle_o   (rx_idle)
  );

  pkt_state_e  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  hdr_q, hdr_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] tmo_q, tmo_d;
  logic [31:0] counter_q, counter_d;
  logic [7:0]  header_q, header_d;
  logic        frame_valid_q, frame_valid_d;
  logic        frame_err_q, frame_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= P_IDLE;
      cnt_q         <= '0;
      hdr_q         <= '0;
      acc_q         <= '0;
      tmo_q         <= '0;
      counter_q     <= '0;
      header_q      <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hdr_q         <= hdr_d;
      acc_q         <= acc_d;
      tmo_q         <= tmo_d;
      counter_q     <= counter_d;
      header_q      <= header_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hdr_d   = hdr_q;
    acc_d   = acc_q;
    tmo_d   = tmo_q;
    case (state_q)
      P_IDLE: begin
        tmo_d = '0;
        if (byte_valid && byte_data != '0 &&
            (EXPECT_HEADER == '0 || byte_data == EXPECT_HEADER)) begin
          hdr_d   = byte_data;
          cnt_d   = '0;
          state_d = P_COLLECT;
        end
      end
      P_COLLECT: begin
        // A byte landing on the expiry cycle wins over the timeout.
        if (byte_valid) begin
          acc_d[{cnt_q, 3'b000} +: 8] = byte_data;
          cnt_d = cnt_q + 2'd1;
          tmo_d = '0;
          if (cnt_q == LAST_IDX) state_d = P_DONE;
        end else if (byte_err) begin
          state_d = P_ABORT;
        end else if (tmo_q >= TIMEOUT_CYCLES) begin
          state_d = P_ABORT;
        end else if (rx_idle) begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      P_DONE, P_ABORT: begin
        tmo_d   = '0;
        state_d = P_IDLE;
      end
      default: state_d = P_IDLE;
    endcase
  end

  always_comb begin
    frame_valid_d = (state_q == P_DONE);
    frame_err_d   = (state_q == P_ABORT);
    counter_d     = (state_q == P_DONE) ? acc_q : counter_q;
    header_d      = (state_q == P_DONE) ? hdr_q : header_q;
    busy          = (state_q == P_COLLECT);
  end

  assign counter_out = counter_q;
  assign header_out  = header_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;

endmodule
